// File: rtl/fetch_pc_gen_pkg.sv
// Shared front-end definitions for the PC-generation stage.
//   XLEN_WIDTH        : architectural address width
//   BTB_ENTRY_NUM     : BTB depth used by the IF-stage top
//   RESET_PC_DEFAULT  : default first fetch address after reset
//   pcg_state_t       : PC-generation sequencing states
//   align_pc          : clears the two low address bits of a fetch address
package fetch_pc_gen_pkg;

  localparam int unsigned XLEN_WIDTH    = 32;
  localparam int unsigned BTB_ENTRY_NUM = 16;

  localparam logic [XLEN_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCG_BOOT,
    PCG_RUN,
    PCG_BUBBLE
  } pcg_state_t;

  function automatic logic [XLEN_WIDTH-1:0] align_pc(input logic [XLEN_WIDTH-1:0] pc);
    return pc & ~XLEN_WIDTH'(3);
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// PC-generation stage for the dual-issue front end.
// Holds the fetch-pair PC, presents both slot PCs to the BTB/IF stage,
// turns same-cycle BTB hits into the next fetch PC, and applies EXE
// redirects and IF back-pressure.
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   if_ready                      IF accepts the current pair
//   redirect_valid, redirect_pc   EXE redirect request and target
//   instr0/1_btb_hit, _target_addr  BTB lookup results for each slot
//   IF_instr0_pc, IF_instr1_pc    slot PCs (slot 1 = slot 0 + INSTR_BYTES)
//   pc_valid, instr1_valid        pair valid / slot 1 not killed
//   instr0/1_pred_taken           per-slot taken prediction
//   pred_target                   predicted next PC, 0 when not taken
//   redirect_cnt                  saturating count of redirects
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [XLEN_WIDTH-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int unsigned           INSTR_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_ready,
  input  logic                  redirect_valid,
  input  logic [XLEN_WIDTH-1:0] redirect_pc,
  input  logic                  instr0_btb_hit,
  input  logic [XLEN_WIDTH-1:0] instr0_btb_target_addr,
  input  logic                  instr1_btb_hit,
  input  logic [XLEN_WIDTH-1:0] instr1_btb_target_addr,
  output logic [XLEN_WIDTH-1:0] IF_instr0_pc,
  output logic [XLEN_WIDTH-1:0] IF_instr1_pc,
  output logic                  pc_valid,
  output logic                  instr1_valid,
  output logic                  instr0_pred_taken,
  output logic                  instr1_pred_taken,
  output logic [XLEN_WIDTH-1:0] pred_target,
  output logic [15:0]           redirect_cnt
);

  localparam logic [XLEN_WIDTH-1:0] SLOT_STEP = XLEN_WIDTH'(INSTR_BYTES);
  localparam logic [XLEN_WIDTH-1:0] PAIR_STEP = XLEN_WIDTH'(2 * INSTR_BYTES);

  pcg_state_t            state_q;
  pcg_state_t            state_d;
  logic [XLEN_WIDTH-1:0] pc_q;
  logic [XLEN_WIDTH-1:0] pc_d;
  logic                  fire;

  assign IF_instr0_pc = align_pc(pc_q);
  assign IF_instr1_pc = IF_instr0_pc + SLOT_STEP;

  assign pc_valid = (state_q == PCG_RUN);
  assign fire     = pc_valid & if_ready;

  // A slot-0 taken prediction kills slot 1 and masks its own hit.
  assign instr0_pred_taken = pc_valid & instr0_btb_hit;
  assign instr1_pred_taken = pc_valid & ~instr0_btb_hit & instr1_btb_hit;
  assign instr1_valid      = pc_valid & ~instr0_btb_hit;

  always_comb begin
    pred_target = '0;
    if (instr0_pred_taken) begin
      pred_target = instr0_btb_target_addr;
    end else if (instr1_pred_taken) begin
      pred_target = instr1_btb_target_addr;
    end
  end

  // Redirect takes priority in every state, including BOOT and BUBBLE.
  // Each redirect is followed by a BUBBLE so the BTB lookup sees the new PC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      pc_d    = align_pc(redirect_pc);
      state_d = PCG_BUBBLE;
    end else begin
      unique case (state_q)
        PCG_BOOT:   state_d = PCG_RUN;
        PCG_BUBBLE: state_d = PCG_RUN;
        PCG_RUN: begin
          if (fire) begin
            if (instr0_btb_hit) begin
              pc_d = align_pc(instr0_btb_target_addr);
            end else if (instr1_btb_hit) begin
              pc_d = align_pc(instr1_btb_target_addr);
            end else begin
              pc_d = pc_q + PAIR_STEP;
            end
          end
        end
        default:    state_d = PCG_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= PCG_BOOT;
      pc_q         <= RESET_PC;
      redirect_cnt <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect_valid && (redirect_cnt != '1)) begin
        redirect_cnt <= redirect_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: each step schedules inputs and the
// expected outputs; inputs are driven on the falling edge, the expected
// record is pushed, and outputs are compared 1 time unit later.
module tb_fetch_pc_gen;

  typedef struct packed {
    logic        v;
    logic [31:0] pc0;
    logic [31:0] pc1;
    logic        i1v;
    logic        p0;
    logic        p1;
    logic [31:0] tgt;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic        rn;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        h0;
    logic [31:0] t0;
    logic        h1;
    logic [31:0] t1;
    obs_t        e;
  } stim_t;

  logic        clk;
  logic        reset_n;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr0_btb_hit;
  logic [31:0] instr0_btb_target_addr;
  logic        instr1_btb_hit;
  logic [31:0] instr1_btb_target_addr;
  logic [31:0] IF_instr0_pc;
  logic [31:0] IF_instr1_pc;
  logic        pc_valid;
  logic        instr1_valid;
  logic        instr0_pred_taken;
  logic        instr1_pred_taken;
  logic [31:0] pred_target;
  logic [15:0] redirect_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;
  stim_t       stim_q[$];
  obs_t        exp_q[$];
  obs_t        got;
  obs_t        e;

  fetch_pc_gen #(
    .RESET_PC    (32'h0000_0000),
    .INSTR_BYTES (4)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .if_ready               (if_ready),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .instr0_btb_hit         (instr0_btb_hit),
    .instr0_btb_target_addr (instr0_btb_target_addr),
    .instr1_btb_hit         (instr1_btb_hit),
    .instr1_btb_target_addr (instr1_btb_target_addr),
    .IF_instr0_pc           (IF_instr0_pc),
    .IF_instr1_pc           (IF_instr1_pc),
    .pc_valid               (pc_valid),
    .instr1_valid           (instr1_valid),
    .instr0_pred_taken      (instr0_pred_taken),
    .instr1_pred_taken      (instr1_pred_taken),
    .pred_target            (pred_target),
    .redirect_cnt           (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit 10000000", $time);
    $fatal(1);
  end

  function automatic obs_t mk(input logic v, input logic [31:0] pc0, input logic i1v,
                              input logic p0, input logic p1, input logic [31:0] tgt,
                              input logic [15:0] cnt);
    obs_t o;
    o.v   = v;
    o.pc0 = pc0;
    o.pc1 = pc0 + 32'd4;
    o.i1v = i1v;
    o.p0  = p0;
    o.p1  = p1;
    o.tgt = tgt;
    o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.v   = pc_valid;
    o.pc0 = IF_instr0_pc;
    o.pc1 = IF_instr1_pc;
    o.i1v = instr1_valid;
    o.p0  = instr0_pred_taken;
    o.p1  = instr1_pred_taken;
    o.tgt = pred_target;
    o.cnt = redirect_cnt;
    return o;
  endfunction

  task automatic sched(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic h0, input logic [31:0] t0, input logic h1,
                       input logic [31:0] t1, input obs_t ex);
    stim_t s;
    s.rn = rn; s.rdy = rdy; s.rv = rv; s.rpc = rpc;
    s.h0 = h0; s.t0 = t0; s.h1 = h1; s.t1 = t1; s.e = ex;
    stim_q.push_back(s);
  endtask

  task automatic drive_step(input stim_t s);
    @(negedge clk);
    reset_n                = s.rn;
    if_ready               = s.rdy;
    redirect_valid         = s.rv;
    redirect_pc            = s.rpc;
    instr0_btb_hit         = s.h0;
    instr0_btb_target_addr = s.t0;
    instr1_btb_hit         = s.h1;
    instr1_btb_target_addr = s.t1;
    exp_q.push_back(s.e);
    #1;
  endtask

  task automatic test_reset();
    sched('0, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h0, '0, '0, '0, 32'h0, 16'h0));
    sched('0, '1, '1, 32'h80, '0, 32'h0, '0, 32'h0, mk('0, 32'h0, '0, '0, '0, 32'h0, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h0, '0, '0, '0, 32'h0, 16'h0));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_reset: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_sequential();
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h0, '1, '0, '0, 32'h0, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h8, '1, '0, '0, 32'h0, 16'h0));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_sequential: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_btb();
    sched('1, '1, '0, 32'h0, '1, 32'h200, '0, 32'h0, mk('1, 32'h10, '0, '1, '0, 32'h200, 16'h0));
    sched('1, '1, '0, 32'h0, '1, 32'h20, '0, 32'h0, mk('1, 32'h200, '0, '1, '0, 32'h20, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'hDEAD_0000, '1, 32'h3F0,
          mk('1, 32'h20, '1, '0, '1, 32'h3F0, 16'h0));
    sched('1, '1, '0, 32'h0, '1, 32'h43, '1, 32'h999, mk('1, 32'h3F0, '0, '1, '0, 32'h43, 16'h0));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_btb: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_stall();
    sched('1, '0, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h40, '1, '0, '0, 32'h0, 16'h0));
    sched('1, '0, '0, 32'h0, '0, 32'h0, '1, 32'h800, mk('1, 32'h40, '1, '0, '1, 32'h800, 16'h0));
    sched('1, '0, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h40, '1, '0, '0, 32'h0, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h40, '1, '0, '0, 32'h0, 16'h0));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_stall: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_redirect();
    sched('1, '1, '1, 32'h1003, '0, 32'h0, '0, 32'h0, mk('1, 32'h48, '1, '0, '0, 32'h0, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h1000, '0, '0, '0, 32'h0, 16'h1));
    sched('1, '0, '1, 32'h2000, '0, 32'h0, '0, 32'h0, mk('1, 32'h1000, '1, '0, '0, 32'h0, 16'h1));
    sched('1, '1, '1, 32'h3006, '1, 32'h50, '0, 32'h0, mk('0, 32'h2000, '0, '0, '0, 32'h0, 16'h2));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h3004, '0, '0, '0, 32'h0, 16'h3));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h3004, '1, '0, '0, 32'h0, 16'h3));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_redirect: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_wrap();
    sched('1, '1, '1, 32'hFFFF_FFF8, '0, 32'h0, '0, 32'h0,
          mk('1, 32'h300C, '1, '0, '0, 32'h0, 16'h3));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'hFFFF_FFF8, '0, '0, '0, 32'h0, 16'h4));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'hFFFF_FFF8, '1, '0, '0, 32'h0, 16'h4));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h0, '1, '0, '0, 32'h0, 16'h4));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h8, '1, '0, '0, 32'h0, 16'h4));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_wrap: got=%h exp=%h", got, e); end
    end
  endtask

  // Counter enters at 4; 65531 redirect edges bring it to 0xFFFF exactly.
  task automatic test_saturation();
    @(negedge clk);
    reset_n = '1; if_ready = '1; redirect_valid = '1; redirect_pc = 32'h100;
    instr0_btb_hit = '0; instr1_btb_hit = '0;
    exp_q.push_back(mk('0, 32'h100, '0, '0, '0, 32'h0, 16'hFFFE));
    repeat (65530) @(negedge clk);
    #1;
    got = observe(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL test_saturation_near: got=%h exp=%h", got, e); end
    exp_q.push_back(mk('0, 32'h100, '0, '0, '0, 32'h0, 16'hFFFF));
    @(negedge clk);
    #1;
    got = observe(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL test_saturation_hit: got=%h exp=%h", got, e); end
    exp_q.push_back(mk('0, 32'h100, '0, '0, '0, 32'h0, 16'hFFFF));
    repeat (10) @(negedge clk);
    #1;
    got = observe(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL test_saturation_hold: got=%h exp=%h", got, e); end
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h100, '0, '0, '0, 32'h0, 16'hFFFF));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h100, '1, '0, '0, 32'h0, 16'hFFFF));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_saturation_exit: got=%h exp=%h", got, e); end
    end
  endtask

  task automatic test_reset_in_bubble();
    sched('1, '1, '1, 32'h500, '0, 32'h0, '0, 32'h0, mk('1, 32'h108, '1, '0, '0, 32'h0, 16'hFFFF));
    sched('0, '1, '1, 32'h700, '0, 32'h0, '0, 32'h0, mk('0, 32'h500, '0, '0, '0, 32'h0, 16'hFFFF));
    sched('1, '1, '1, 32'h600, '0, 32'h0, '0, 32'h0, mk('0, 32'h0, '0, '0, '0, 32'h0, 16'h0));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('0, 32'h600, '0, '0, '0, 32'h0, 16'h1));
    sched('1, '1, '0, 32'h0, '0, 32'h0, '0, 32'h0, mk('1, 32'h600, '1, '0, '0, 32'h0, 16'h1));
    while (stim_q.size() > 0) begin
      drive_step(stim_q.pop_front());
      got = observe(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL test_reset_in_bubble: got=%h exp=%h", got, e); end
    end
  endtask

  initial begin
    reset_n                = '0;
    if_ready               = '1;
    redirect_valid         = '0;
    redirect_pc            = '0;
    instr0_btb_hit         = '0;
    instr0_btb_target_addr = '0;
    instr1_btb_hit         = '0;
    instr1_btb_target_addr = '0;
    test_reset();
    test_sequential();
    test_btb();
    test_stall();
    test_redirect();
    test_wrap();
    test_saturation();
    test_reset_in_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
